// File: rtl/cpu_parameters.sv
// Shared CPU parameters for the integer memory stage: data width, lane count,
// memory FSM states, load/store funct3 codes, request record and helpers for
// store lane steering and alignment checks.
package cpu_parameters;

  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request as latched from execute.
  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [2:0]      funct3;
    logic [4:0]      rd;
  } mem_req_t;

  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfword on an odd byte, or word not on a word boundary.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  // Byte enables; halfwords pick their lane pair from adr[1] only.
  function automatic logic [NUM_LANES-1:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across every lane so the slave can pick any.
  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   return {NUM_LANES{d[7:0]}};
      2'b01:   return {(NUM_LANES/2){d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/intirvx_memory_if.sv
// Bundle of the execute request, data bus and write-back result handshakes.
// slave = memory stage view, master = surrounding pipeline / bus view.
interface intirvx_memory_if;
  import cpu_parameters::*;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_adr;
  logic [XLEN-1:0] ex_wdata;
  logic            ex_we;
  logic [2:0]      ex_funct3;
  logic [4:0]      ex_rd;

  logic                 dbus_req;
  logic                 dbus_we;
  logic [XLEN-1:0]      dbus_adr;
  logic [NUM_LANES-1:0] dbus_be;
  logic [XLEN-1:0]      dbus_wdata;
  logic                 dbus_gnt;
  logic                 dbus_rvalid;
  logic                 dbus_err;
  logic [XLEN-1:0]      dbus_rdata;

  logic [XLEN-1:0] mem_res;
  logic [4:0]      mem_rd;
  logic            mem_exception;
  logic            mem_valid;
  logic            mem_ready;

  modport slave (
    input  ex_valid, ex_adr, ex_wdata, ex_we, ex_funct3, ex_rd,
    output ex_ready,
    output dbus_req, dbus_we, dbus_adr, dbus_be, dbus_wdata,
    input  dbus_gnt, dbus_rvalid, dbus_err, dbus_rdata,
    output mem_res, mem_rd, mem_exception, mem_valid,
    input  mem_ready
  );

  modport master (
    output ex_valid, ex_adr, ex_wdata, ex_we, ex_funct3, ex_rd,
    input  ex_ready,
    input  dbus_req, dbus_we, dbus_adr, dbus_be, dbus_wdata,
    output dbus_gnt, dbus_rvalid, dbus_err, dbus_rdata,
    input  mem_res, mem_rd, mem_exception, mem_valid,
    output mem_ready
  );

endinterface

// File: rtl/intirvx_load_align.sv
// Combinational load extract/extend: selects the byte or halfword addressed
// by the low address bits and sign- or zero-extends it; words pass through.
module intirvx_load_align
  import cpu_parameters::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_adr_lo,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_res
);

  logic [NUM_LANES-1:0][7:0] w_lanes;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;

  assign w_lanes = i_rdata;
  assign w_byte  = w_lanes[i_adr_lo];
  // adr[0] is ignored for halfwords; a misaligned half reads its aligned pair.
  assign w_half  = i_adr_lo[1] ? {w_lanes[3], w_lanes[2]} : {w_lanes[1], w_lanes[0]};

  // Extend the selected field by funct3.
  always_comb begin
    o_res = i_rdata;
    case (i_funct3)
      F3_B:    o_res = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_BU:   o_res = {{(XLEN-8){1'b0}}, w_byte};
      F3_H:    o_res = {{(XLEN-16){w_half[15]}}, w_half};
      F3_HU:   o_res = {{(XLEN-16){1'b0}}, w_half};
      default: o_res = i_rdata;
    endcase
  end

endmodule

// File: rtl/intirvx_memory.sv
// Integer load/store unit: accepts one request from execute, runs a single
// data-bus transaction (req/gnt then rvalid) and hands the result to write
// back. Unsupported funct3 bypasses the bus with an exception.
// Optional macro INTIRVX_MISALIGN_TRAP_EN: misaligned H/W accesses also
// bypass the bus with an exception; otherwise the low bits are ignored.
module intirvx_memory
  import cpu_parameters::*;
(
  input  logic              clk,
  input  logic              rst_n,
  intirvx_memory_if.slave   bus
);

  mem_state_t           r_state, w_state_nxt;
  mem_req_t             r_req;
  logic [NUM_LANES-1:0] r_be;
  logic [XLEN-1:0]      r_res;
  logic                 r_exc;
  logic                 w_accept;
  logic                 w_bad;
  logic                 w_resp;
  logic [XLEN-1:0]      w_load;

  assign w_accept = bus.ex_valid && (r_state == IDLE);
  assign w_resp   = bus.dbus_rvalid && (r_state == WAIT);

`ifdef INTIRVX_MISALIGN_TRAP_EN
  assign w_bad = !f3_supported(bus.ex_funct3) || f3_misaligned(bus.ex_funct3, bus.ex_adr[1:0]);
`else
  assign w_bad = !f3_supported(bus.ex_funct3);
`endif

  intirvx_load_align u_align (
    .i_rdata  (bus.dbus_rdata),
    .i_adr_lo (r_req.adr[1:0]),
    .i_funct3 (r_req.funct3),
    .o_res    (w_load)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake strobes.
  always_comb begin
    w_state_nxt   = r_state;
    bus.ex_ready  = 1'b0;
    bus.dbus_req  = 1'b0;
    bus.mem_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.ex_ready = 1'b1;
        if (bus.ex_valid) w_state_nxt = w_bad ? DONE : REQ;
      end
      REQ: begin
        bus.dbus_req = 1'b1;
        if (bus.dbus_gnt) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.dbus_rvalid) w_state_nxt = DONE;
      end
      DONE: begin
        bus.mem_valid = 1'b1;
        if (bus.mem_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the request on accept; latch the result on the bus response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
      r_be  <= '0;
      r_res <= '0;
      r_exc <= 1'b0;
    end else if (w_accept) begin
      r_req.adr    <= bus.ex_adr;
      r_req.wdata  <= store_wdata(bus.ex_funct3, bus.ex_wdata);
      r_req.we     <= bus.ex_we;
      r_req.funct3 <= bus.ex_funct3;
      r_req.rd     <= bus.ex_rd;
      r_be         <= store_be(bus.ex_funct3, bus.ex_adr[1:0]);
      r_exc        <= w_bad;
      r_res        <= w_bad ? bus.ex_adr : '0;
    end else if (w_resp) begin
      r_exc <= bus.dbus_err;
      if (bus.dbus_err)  r_res <= r_req.adr;
      else if (r_req.we) r_res <= '0;
      else               r_res <= w_load;
    end
  end

  assign bus.dbus_we       = r_req.we && (r_state == REQ);
  assign bus.dbus_adr      = {r_req.adr[XLEN-1:2], 2'b00};
  assign bus.dbus_be       = r_be;
  assign bus.dbus_wdata    = r_req.wdata;
  assign bus.mem_res       = r_res;
  assign bus.mem_rd        = r_req.we ? 5'd0 : r_req.rd;
  assign bus.mem_exception = r_exc;

endmodule

// File: tb/tb_intirvx_memory.sv
// Self-checking bench for intirvx_memory: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_intirvx_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  intirvx_memory_if bif ();

  intirvx_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_bad(input logic [2:0] f3, input logic [31:0] adr);
    int lo = int'(adr % 4);
    int sz = int'(f3) % 4;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
`ifdef INTIRVX_MISALIGN_TRAP_EN
    if (sz == 1 && (lo % 2) != 0) return 1;
    if (sz == 2 && lo != 0) return 1;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] d);
    int lo = int'(adr % 4);
    logic [31:0] b = (d >> (8 * lo)) % 256;
    logic [31:0] h = (d >> (8 * (lo / 2) * 2)) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd5: return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] adr);
    int lo = int'(adr % 4);
    case (int'(f3) % 4)
      0: return 32'd1 << lo;
      1: return 32'd3 << ((lo / 2) * 2);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (int'(f3) % 4)
      0: return (d % 256) * 32'h01010101;
      1: return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // One full transaction: drive, act as bus slave, check bus and result.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic [4:0] rd,
                         input logic err, input int gdly, input int rdly, input int mdly);
    bit          bad = m_bad(f3, adr);
    logic [31:0] exp_res;
    logic [4:0]  exp_rd = we ? 5'd0 : rd;
    bit          exp_exc = bad || err;
    int          edges;
    int          w;
    if (bad || err) exp_res = adr;
    else            exp_res = m_load(f3, adr, rdata);

    check("ex_ready_idle", bif.ex_ready, 1);
    bif.ex_valid = 1; bif.ex_we = we; bif.ex_funct3 = f3; bif.ex_adr = adr;
    bif.ex_wdata = wd; bif.ex_rd = rd;
    @(posedge clk); #1;
    bif.ex_valid = 0; bif.ex_adr = $urandom; bif.ex_wdata = $urandom;
    edges = 1;
    if (!bad) begin
      for (int i = 0; i < gdly; i++) begin
        check("req_held", bif.dbus_req, 1);
        check("adr_held", bif.dbus_adr, adr & 32'hFFFF_FFFC);
        @(posedge clk); #1; edges++;
      end
      check("dbus_req", bif.dbus_req, 1);
      check("dbus_adr", bif.dbus_adr, adr & 32'hFFFF_FFFC);
      check("dbus_we", bif.dbus_we, we);
      if (we) begin
        check("dbus_be", bif.dbus_be, m_be(f3, adr));
        check("dbus_wdata", bif.dbus_wdata, m_wdata(f3, wd));
      end
      bif.dbus_gnt = 1;
      @(posedge clk); #1; edges++;
      bif.dbus_gnt = 0;
      for (int i = 0; i < rdly; i++) begin
        check("req_dropped", bif.dbus_req, 0);
        @(posedge clk); #1; edges++;
      end
      bif.dbus_rvalid = 1; bif.dbus_err = err; bif.dbus_rdata = rdata;
      @(posedge clk); #1; edges++;
      bif.dbus_rvalid = 0; bif.dbus_err = 0; bif.dbus_rdata = $urandom;
    end else begin
      check("no_bus_req", bif.dbus_req, 0);
    end
    w = 0;
    while (!bif.mem_valid && w < 8) begin
      check("no_bus_req_bad", bif.dbus_req & bad, 0);
      @(posedge clk); #1; edges++; w++;
    end
    check("mem_valid", bif.mem_valid, 1);
    if (!bad && gdly == 0 && rdly == 0) check("latency", edges, 3);
    for (int i = 0; i <= mdly; i++) begin
      if (i > 0) check("valid_held", bif.mem_valid, 1);
      check("mem_exc", bif.mem_exception, exp_exc);
      check("mem_rd", bif.mem_rd, exp_rd);
      if (!we || exp_exc) check("mem_res", bif.mem_res, exp_res);
      if (i == mdly) bif.mem_ready = 1;
      @(posedge clk); #1;
    end
    bif.mem_ready = 0;
    check("valid_clr", bif.mem_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, bif.dbus_req, 0);
    check({tag, "_we"}, bif.dbus_we, 0);
    check({tag, "_be"}, bif.dbus_be, 0);
    check({tag, "_adr"}, bif.dbus_adr, 0);
    check({tag, "_wdata"}, bif.dbus_wdata, 0);
    check({tag, "_valid"}, bif.mem_valid, 0);
    check({tag, "_exc"}, bif.mem_exception, 0);
    check({tag, "_res"}, bif.mem_res, 0);
    check({tag, "_rd"}, bif.mem_rd, 0);
    check({tag, "_ready"}, bif.ex_ready, 1);
  endtask

  initial begin
    bif.ex_valid = 0; bif.ex_adr = 0; bif.ex_wdata = 0; bif.ex_we = 0;
    bif.ex_funct3 = 0; bif.ex_rd = 0; bif.dbus_gnt = 0; bif.dbus_rvalid = 0;
    bif.dbus_err = 0; bif.dbus_rdata = 0; bif.mem_ready = 0;
    repeat (3) @(posedge clk);
    #1; check_reset_vals("rst_in");
    rst_n = 1;
    @(posedge clk); #1;
    check_reset_vals("rst_out");

    // stray response while idle must be ignored
    bif.dbus_rvalid = 1; bif.dbus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1; bif.dbus_rvalid = 0;
    check("stray_valid", bif.mem_valid, 0);
    check("stray_res", bif.mem_res, 0);

    // directed scenarios
    run_txn(0, 3'b000, 32'h103, 0, 32'h80112233, 5'd7, 0, 0, 0, 0);        // LB
    run_txn(1, 3'b001, 32'h202, 32'h0000ABCD, 0, 5'd9, 0, 0, 0, 0);        // SH
    run_txn(0, 3'b101, 32'h10, 0, 32'h1234F00D, 5'd3, 0, 4, 0, 2);         // LHU
    run_txn(0, 3'b010, 32'h40, 0, 32'h55555555, 5'd4, 1, 0, 0, 0);         // LW err
    run_txn(0, 3'b010, 32'h41, 0, 32'hCAFEF00D, 5'd5, 0, 0, 0, 0);         // LW misaligned
    run_txn(0, 3'b011, 32'h80, 0, 32'h0, 5'd6, 0, 0, 0, 1);                // unsupported
    run_txn(1, 3'b000, 32'h303, 32'h000000A5, 0, 5'd2, 0, 1, 1, 0);        // SB lane 3

    // reset during WAIT abandons the access; a late response is ignored
    bif.ex_valid = 1; bif.ex_we = 0; bif.ex_funct3 = 3'b010; bif.ex_adr = 32'h80; bif.ex_rd = 5'd11;
    @(posedge clk); #1; bif.ex_valid = 0; bif.dbus_gnt = 1;
    @(posedge clk); #1; bif.dbus_gnt = 0;
    rst_n = 0; #1;
    check_reset_vals("rst_mid");
    @(posedge clk); #1; rst_n = 1;
    bif.dbus_rvalid = 1; bif.dbus_rdata = 32'h12345678;
    @(posedge clk); #1; bif.dbus_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("late_rsp_valid", bif.mem_valid, 0);
      @(posedge clk); #1;
    end
    check_reset_vals("rst_after");

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic       we = 1'($urandom_range(0, 1));
      logic [2:0] f3;
      int         pick = $urandom_range(0, 7);
      if (we) begin
        case (pick % 6)
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
          3: f3 = 3'b011; 4: f3 = 3'b110; default: f3 = 3'b111;
        endcase
      end else f3 = 3'(pick);
      run_txn(we, f3, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 7) == 0), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
